op_result_demux: RTL and testbench
==================================

// Module: op_result_demux
// PURPOSE
//  1-to-8 demultiplexer with capture registers and an auto-sweep sequencer. It is the
//  write side of the 8-op mux path. During a sweep it drives the 3-bit select into
//  mux_8x1, waits for the mux output to settle, then stores that output into the slot
//  with the same index. It also accepts single manual writes to any slot. The captured
//  8-op result vector then goes to the checker/display logic.
// PARAMETERS
//  WIDTH   1  width of one result (din, each slot)
//  SETTLE  1  cycles sel_out is held before capture; legal range >=1
// PORTS
//  clk          in   1          system clock, all logic on rising edge
//  rst          in   1          synchronous, active-high reset
//  din          in   WIDTH      result from mux_8x1 output (cout)
//  wr_en        in   1          manual write strobe (honoured only in IDLE)
//  wr_sel       in   3          manual write slot index
//  sweep_start  in   1          1-cycle pulse: begin capture sweep of slots 0..7
//  sel_out      out  3          select to mux_8x1 {s2,s1,s0}
//  slots        out  8*WIDTH    slot k occupies bits [k*WIDTH +: WIDTH]
//  valid        out  8          valid[k]=1 once slot k has been written
//  busy         out  1          high in SETTLE/CAPTURE
//  done         out  1          1-cycle pulse when the sweep finishes
// BEHAVIOUR
//  - Reset: state=IDLE, sel_out=0, slots=0, valid=0, busy=0, done=0, settle counter=0.
//    Reset mid-sweep aborts the sweep with no done pulse.
//  - States: IDLE, SETTLE, CAPTURE, DONE. All outputs are registered.
//  - IDLE, sweep_start=1: next cycle state=SETTLE, sel_out=0, cnt=0, valid=0
//    (slots keep their old data), busy=1.
//  - IDLE, wr_en=1 and sweep_start=0: slots[wr_sel]<=din and valid[wr_sel]<=1 next cycle.
//  - IDLE, sweep_start and wr_en together: the sweep wins and the write is dropped.
//  - SETTLE: cnt increments each cycle. When cnt==SETTLE-1, go to CAPTURE.
//  - CAPTURE (one cycle): slots[sel_out]<=din, valid[sel_out]<=1.
//    If sel_out==7, go to DONE. Otherwise sel_out<=sel_out+1, cnt<=0, go to SETTLE.
//    sel_out never wraps to 0 within a sweep.
//  - DONE (one cycle): done=1, busy=0, sel_out held at 7, then return to IDLE.
//  - While busy or in DONE, sweep_start and wr_en are ignored; there is no queueing.
//  - Timing: each slot costs SETTLE+1 cycles. done is high in cycle 8*(SETTLE+1)+1,
//    counting the cycle after sweep_start as cycle 1.
//  - din is sampled only in CAPTURE, or in IDLE with wr_en. It is ignored otherwise.
// STRUCTURE
//  - Shared package/header: state encodings (ST_IDLE=0, ST_SETTLE=1, ST_CAPTURE=2,
//    ST_DONE=3), N_SLOTS=8, SEL_W=3.
//  - One sub-module, sweep_ctrl: the FSM plus settle counter and sel_out counter. It
//    outputs cap_en and cap_idx. The top level holds the slot/valid register bank and the
//    manual-write arbitration.
// TESTING (WIDTH=1, SETTLE=1; mux_8x1 + all_ops in loop, in1=1 in2=0)
//  1 Reset asserted mid-sweep (sel_out=4) -> next cycle all outputs 0, state IDLE,
//    no done pulse afterwards.
//  2 sweep_start pulse -> sel_out steps 0..7, each value held 2 cycles; done high at
//    cycle 17 only; slots=8'h2E, valid=8'hFF.
//  3 Sweep with in1=1 in2=1 -> slots=8'b1000_1001 (AND, OR, XNOR set), valid=8'hFF.
//  4 IDLE: wr_en=1, wr_sel=5, din=1 -> slots[5]=1, valid=8'h20 (from reset);
//    other slots unchanged.
//  5 sweep_start and wr_en (wr_sel=2) in the same cycle -> no manual write; sweep runs;
//    valid cleared, then refills 0x01..0xFF.
//  6 sweep_start and wr_en pulsed at sel_out=3 mid-sweep -> ignored; done occurs exactly
//    once at cycle 17; slot contents match scenario 2.

Source files
------------

// File: rtl/op_result_demux_pkg.sv
// Shared encodings and sizes for the 8-slot result demux and its sweep sequencer.
package op_result_demux_pkg;

  localparam int N_SLOTS = 8;
  localparam int SEL_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Capture request from the sequencer to the slot bank.
  typedef struct packed {
    logic             en;
    logic [SEL_W-1:0] idx;
  } cap_t;

  function automatic logic [N_SLOTS-1:0] slot_onehot(input logic [SEL_W-1:0] idx);
    return N_SLOTS'(1) << idx;
  endfunction

endpackage

// File: rtl/op_result_demux_if.sv
// Bus bundle between the op mux path and the result demux: write side in, capture bank out.
interface op_result_demux_if #(parameter int WIDTH = 1);
  import op_result_demux_pkg::*;

  logic [WIDTH-1:0]         din;
  logic                     wr_en;
  logic [SEL_W-1:0]         wr_sel;
  logic                     sweep_start;
  logic [SEL_W-1:0]         sel_out;
  logic [N_SLOTS*WIDTH-1:0] slots;
  logic [N_SLOTS-1:0]       valid;
  logic                     busy;
  logic                     done;

  modport master (
    output din, wr_en, wr_sel, sweep_start,
    input  sel_out, slots, valid, busy, done
  );

  modport slave (
    input  din, wr_en, wr_sel, sweep_start,
    output sel_out, slots, valid, busy, done
  );

endinterface

// File: rtl/op_result_demux_sweep_ctrl.sv
// Sweep sequencer: walks sel_out 0..7, holding each select SETTLE cycles before a capture.
module op_result_demux_sweep_ctrl
  import op_result_demux_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sweep_start,
  output logic [SEL_W-1:0] sel_out,
  output logic             busy,
  output logic             done,
  output logic             idle,
  output logic             start_acc,
  output cap_t             cap
);

  localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  assign idle      = (state == ST_IDLE);
  assign start_acc = idle && sweep_start;
  assign cap.en    = (state == ST_CAPTURE);
  assign cap.idx   = sel_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      sel_out <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (sweep_start) begin
            state   <= ST_SETTLE;
            sel_out <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
          end
        end
        ST_SETTLE: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(SETTLE - 1)) state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          cnt <= '0;
          // Last slot ends the sweep; sel_out parks at 7 rather than wrapping.
          if (sel_out == SEL_W'(N_SLOTS - 1)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            sel_out <= sel_out + SEL_W'(1);
            state   <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/op_result_demux.sv
// 1-to-8 result demux: capture bank fed by the sweep sequencer or by manual idle writes.
module op_result_demux
  import op_result_demux_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  op_result_demux_if.slave   bus
);

  logic [SEL_W-1:0]              sel_out;
  logic                          busy, done, idle, start_acc;
  cap_t                          cap;
  logic                          man_wr;
  logic [N_SLOTS-1:0]            man_hit, cap_hit;
  logic [N_SLOTS-1:0][WIDTH-1:0] slot_q;
  logic [N_SLOTS-1:0]            valid_q;

  op_result_demux_sweep_ctrl #(.SETTLE(SETTLE)) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .sweep_start(bus.sweep_start),
    .sel_out    (sel_out),
    .busy       (busy),
    .done       (done),
    .idle       (idle),
    .start_acc  (start_acc),
    .cap        (cap)
  );

  // A sweep request in the same cycle as a manual write wins; the write is dropped.
  assign man_wr  = idle && bus.wr_en && !bus.sweep_start;
  assign man_hit = man_wr ? slot_onehot(bus.wr_sel) : '0;
  assign cap_hit = cap.en ? slot_onehot(cap.idx)    : '0;

  for (genvar k = 0; k < N_SLOTS; k++) begin : g_slot
    logic             hit;
    logic [WIDTH-1:0] d_q;
    logic             v_q;

    assign hit        = man_hit[k] || cap_hit[k];
    assign slot_q[k]  = d_q;
    assign valid_q[k] = v_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        d_q <= '0;
        v_q <= 1'b0;
      end else begin
        if (hit) d_q <= bus.din;
        if (start_acc) v_q <= 1'b0;
        else if (hit)  v_q <= 1'b1;
      end
    end
  end

  assign bus.sel_out = sel_out;
  assign bus.slots   = slot_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = busy;
  assign bus.done    = done;

endmodule

// File: tb/tb_op_result_demux.sv
// Scoreboarded bench for op_result_demux with a behavioural 8-op mux closing the loop.
module tb_op_result_demux;
  import op_result_demux_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  op_result_demux_if #(.WIDTH(1)) bus();

  op_result_demux #(.WIDTH(1), .SETTLE(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic in1 = 1'b1, in2 = 1'b0, man_mode = 1'b0, man_din = 1'b0;

  function automatic logic op_bit(input logic [2:0] s, input logic a, input logic b);
    case (s)
      3'd0: return a & b;
      3'd1: return ~(a & b);
      3'd2: return a ^ b;
      3'd3: return a | b;
      3'd4: return ~(a | b);
      3'd5: return ~b;
      3'd6: return ~a;
      default: return ~(a ^ b);
    endcase
  endfunction

  assign bus.din = man_mode ? man_din : op_bit(bus.sel_out, in1, in2);

  int errors = 0, checks = 0;
  int cyc = 0;
  int sweep_t0 = -1000;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    logic [7:0] slots;
    logic [7:0] valid;
    int         done_cyc;
  } exp_t;
  exp_t sbq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: per-cycle sweep trace plus scoreboard pop on every done pulse.
  always @(negedge clk) begin
    int k;
    exp_t e;
    if (!rst) begin
      if (bus.busy) begin
        k = (cyc - sweep_t0 - 1) / 2;
        check("trace_sel", 32'(bus.sel_out), 32'(k));
        check("trace_valid", 32'(bus.valid), 32'((1 << k) - 1));
      end
      if (bus.done) begin
        if (sbq.size() == 0) begin
          check("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          e = sbq.pop_front();
          check({e.name, "_slots"}, 32'(bus.slots), 32'(e.slots));
          check({e.name, "_valid"}, 32'(bus.valid), 32'(e.valid));
          check({e.name, "_done_cyc"}, 32'(cyc), 32'(e.done_cyc));
          check({e.name, "_sel_done"}, 32'(bus.sel_out), 32'd7);
          check({e.name, "_busy_done"}, 32'(bus.busy), 32'd0);
        end
      end
    end
  end

  task automatic wait_sel(input logic [2:0] v);
    int n = 0;
    while (!(bus.busy && bus.sel_out == v) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("wait_sel_in_time", 32'(n < 40), 32'd1);
  endtask

  task automatic start_sweep(input string name, input logic [7:0] exp_slots,
                             input logic push, input logic with_wr);
    sweep_t0 = cyc;
    bus.sweep_start = 1'b1;
    bus.wr_en  = with_wr;
    bus.wr_sel = 3'd2;
    if (push) sbq.push_back('{name, exp_slots, 8'hFF, cyc + 17});
    @(negedge clk);
    bus.sweep_start = 1'b0;
    bus.wr_en = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_sel"},   32'(bus.sel_out), 32'd0);
    check({name, "_slots"}, 32'(bus.slots),   32'd0);
    check({name, "_valid"}, 32'(bus.valid),   32'd0);
    check({name, "_busy"},  32'(bus.busy),    32'd0);
    check({name, "_done"},  32'(bus.done),    32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_sel = 3'd0;
    bus.sweep_start = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Reset mid-sweep at sel_out=4: no expectation queued, so any done is flagged.
    start_sweep("abort", 8'h00, 1'b0, 1'b0);
    wait_sel(3'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("midreset");
    repeat (20) @(negedge clk);

    // Manual write in idle from the reset state.
    man_mode = 1'b1; man_din = 1'b1;
    bus.wr_en = 1'b1; bus.wr_sel = 3'd5;
    @(negedge clk);
    bus.wr_en = 1'b0; man_mode = 1'b0;
    check("manual_slots", 32'(bus.slots), 32'h20);
    check("manual_valid", 32'(bus.valid), 32'h20);

    // Full sweep, in1=1 in2=0.
    in1 = 1'b1; in2 = 1'b0;
    start_sweep("sweep10", 8'h2E, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check("sweep10_drained", 32'(sbq.size()), 32'd0);

    // Full sweep, in1=1 in2=1.
    in2 = 1'b1;
    start_sweep("sweep11", 8'h89, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check("sweep11_drained", 32'(sbq.size()), 32'd0);

    // Sweep and manual write together: write dropped, old data kept, valid cleared.
    in2 = 1'b0;
    start_sweep("sweep_wr", 8'h2E, 1'b1, 1'b1);
    check("collide_valid", 32'(bus.valid), 32'h00);
    check("collide_slots", 32'(bus.slots), 32'h89);
    repeat (20) @(negedge clk);
    check("sweep_wr_drained", 32'(sbq.size()), 32'd0);

    // Requests mid-sweep are ignored; done still lands once at cycle 17.
    start_sweep("sweep_mid", 8'h2E, 1'b1, 1'b0);
    wait_sel(3'd3);
    bus.sweep_start = 1'b1; bus.wr_en = 1'b1; bus.wr_sel = 3'd0;
    @(negedge clk);
    bus.sweep_start = 1'b0; bus.wr_en = 1'b0;
    repeat (20) @(negedge clk);
    check("sweep_mid_drained", 32'(sbq.size()), 32'd0);
    check("final_idle_busy", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
